pulse_train_gen: RTL and testbench
==================================

# pulse_train_gen

Programmable pulse-train generator, the transmit-side counterpart of the edge-capture logic in the radar front-end control path. On a single-cycle start strobe it drives a configurable number of pulses with programmable active width and period on one output line. Downstream edge detectors use the line as chirp/frame triggers. It also reports busy, completion and a running pulse count.

## Interface
- EDGE_TYPE, 0, 0 = idle-low line with active-high pulses (leading edge rising); 1 = idle-high line with active-low pulses (leading edge falling)
- CNT_W, 16, width of all width/period/count fields
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start_i  in  1  start strobe; honoured only when idle
- abort_i  in  1  stop train, return line to idle level
- high_cycles_i  in  CNT_W  active-phase width H in cycles; sampled at accepted start
- period_cycles_i  in  CNT_W  pulse period P in cycles; sampled at accepted start
- pulse_num_i  in  CNT_W  number of pulses N; sampled at accepted start
- signal_o  out  1  generated line, registered
- lead_edge_o  out  1  one-cycle strobe in the first active cycle of every pulse
- busy_o  out  1  train in progress
- done_o  out  1  one-cycle strobe on normal completion
- pulse_cnt_o  out  CNT_W  pulses begun in current/last train

## Operation
- States: IDLE, ACTIVE, INACTIVE.
- IDLE:
  - start_i=1 and abort_i=0 → latch config and enter ACTIVE; pulse_cnt_o←1.
  - Exception: N=0 → stay IDLE and strobe done_o next cycle, no pulse.
- Config sanitising at latch: H=0 treated as 1; P≤H treated as H+1. The inactive phase is always ≥1 cycle.
- ACTIVE: signal_o = active level for H cycles, then INACTIVE.
- INACTIVE: signal_o = idle level for P−H cycles. Then:
  - pulses left → ACTIVE, pulse_cnt_o increments.
  - last pulse → IDLE with done_o=1.
- start_i while busy: ignored. Config inputs may change freely after acceptance.
- abort_i in ACTIVE/INACTIVE → IDLE next cycle, signal_o to idle level, busy_o=0, no done_o; pulse_cnt_o holds.
- abort_i and start_i together in IDLE → abort wins, nothing starts.
- rst mid-train → all outputs to reset values next cycle; any train is discarded.
- Reset values: signal_o=EDGE_TYPE (idle level), lead_edge_o=0, busy_o=0, done_o=0, pulse_cnt_o=0, state IDLE.

## Timing
- Start accepted at cycle T → first active cycle T+1, with lead_edge_o=1 at T+1.
- Pulse k (k=0..N−1):
  - active cycles T+1+kP … T+kP+H
  - inactive cycles T+1+kP+H … T+(k+1)P
- busy_o=1 for cycles T+1 … T+NP.
- done_o=1 and busy_o=0 at cycle T+NP+1.
- N=0: done_o at T+1, busy_o never asserted.
- start_i in the done_o cycle is accepted (FSM already IDLE): the next train starts one cycle later, with back-to-back idle gap of exactly one cycle.
- All outputs are registered; no combinational input→output paths.
- Counters: phase counter CNT_W bits, pulse counter CNT_W bits. Maximum values (H=2^CNT_W−1, N=2^CNT_W−1) work without wrap.
- Sanitised P: H+1 may overflow when H = all-ones, so compute the sanitised P at CNT_W+1 bits.

## Structure
- Package pulse_gen_pkg:
  - state enum (IDLE, ACTIVE, INACTIVE)
  - idle/active level constants derived from EDGE_TYPE
  - sanitise function for H/P
- Single module; no sub-module needed. The phase down-counter stays inline.

## Test plan
- EDGE_TYPE=0, H=2, P=5, N=3, start at T:
  - signal_o high at T+1..T+2, T+6..T+7, T+11..T+12; low otherwise
  - lead_edge_o at T+1, T+6, T+11
  - done_o at T+16
  - pulse_cnt_o=3
- EDGE_TYPE=1, H=0, P=0, N=2: sanitised to H=1, P=2; line low at T+1 and T+3, high otherwise; done_o at T+5.
- N=0: no line activity, busy_o stays 0, done_o at T+1, pulse_cnt_o=0.
- abort_i during second pulse's active phase (H=3, P=6, N=4):
  - line idle next cycle, busy_o=0, no done_o
  - pulse_cnt_o=2
  - start_i during the train ignored
- Start in done_o cycle: second train's first active cycle exactly 2 cycles after the first train's last inactive cycle.
- rst asserted mid-INACTIVE: all outputs at reset values next cycle; start_i with rst high is ignored.

Source files
------------

// File: rtl/pulse_gen_pkg.sv
// Shared types and helpers for the pulse-train generator: FSM states, line levels
// and width/period sanitising.
package pulse_gen_pkg;

  // Widest configuration field the helpers accept; callers zero-extend into it.
  localparam int unsigned MaxW = 32;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StActive   = 2'd1,
    StInactive = 2'd2
  } pulse_state_e;

  function automatic logic idle_level(input bit edge_type);
    return edge_type;
  endfunction

  function automatic logic active_level(input bit edge_type);
    return ~edge_type;
  endfunction

  function automatic logic [MaxW-1:0] sanitise_high(input logic [MaxW-1:0] h);
    return (h == '0) ? {{(MaxW-1){1'b0}}, 1'b1} : h;
  endfunction

  // One extra bit: H+1 overflows when H is all-ones.
  function automatic logic [MaxW:0] sanitise_period(input logic [MaxW-1:0] h,
                                                    input logic [MaxW-1:0] p);
    logic [MaxW-1:0] hs;
    hs = sanitise_high(h);
    if (p <= hs) begin
      return {1'b0, hs} + {{MaxW{1'b0}}, 1'b1};
    end
    return {1'b0, p};
  endfunction

endpackage

// File: rtl/pulse_train_gen_if.sv
// Control/status bundle between a pulse-train generator and its controller.
interface pulse_train_gen_if #(
  parameter int unsigned CNT_W = 16
);
  logic             start_i;
  logic             abort_i;
  logic [CNT_W-1:0] high_cycles_i;
  logic [CNT_W-1:0] period_cycles_i;
  logic [CNT_W-1:0] pulse_num_i;
  logic             signal_o;
  logic             lead_edge_o;
  logic             busy_o;
  logic             done_o;
  logic [CNT_W-1:0] pulse_cnt_o;

  modport master (
    output start_i, abort_i, high_cycles_i, period_cycles_i, pulse_num_i,
    input  signal_o, lead_edge_o, busy_o, done_o, pulse_cnt_o
  );

  modport slave (
    input  start_i, abort_i, high_cycles_i, period_cycles_i, pulse_num_i,
    output signal_o, lead_edge_o, busy_o, done_o, pulse_cnt_o
  );
endinterface

// File: rtl/pulse_train_gen.sv
// Programmable pulse-train generator: N pulses of H active cycles every P cycles on one
// registered line, with busy/done/lead-edge strobes and a running pulse count.
module pulse_train_gen
  import pulse_gen_pkg::*;
#(
  parameter bit          EDGE_TYPE = 1'b0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  pulse_train_gen_if.slave bus
);

  localparam logic IdleLvl = idle_level(EDGE_TYPE);
  localparam logic ActLvl  = active_level(EDGE_TYPE);

  pulse_state_e     state_q;
  logic             signal_q;
  logic             lead_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] phase_q;
  logic [CNT_W-1:0] high_m1_q;
  logic [CNT_W-1:0] low_m1_q;
  logic [CNT_W-1:0] num_q;

  logic [CNT_W-1:0] h_san;
  logic [CNT_W:0]   p_san;
  logic [CNT_W-1:0] high_m1;
  logic [CNT_W-1:0] low_m1;

  assign h_san   = CNT_W'(sanitise_high(MaxW'(bus.high_cycles_i)));
  assign p_san   = (CNT_W+1)'(sanitise_period(MaxW'(bus.high_cycles_i),
                                              MaxW'(bus.period_cycles_i)));
  assign high_m1 = h_san - CNT_W'(1);
  // P-H-1 always fits in CNT_W bits once P has been sanitised.
  assign low_m1  = CNT_W'(p_san - {1'b0, h_san} - (CNT_W+1)'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      signal_q  <= IdleLvl;
      lead_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      phase_q   <= '0;
      high_m1_q <= '0;
      low_m1_q  <= '0;
      num_q     <= '0;
    end else begin
      lead_q <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start_i && !bus.abort_i) begin
            if (bus.pulse_num_i == '0) begin
              done_q <= 1'b1;
              cnt_q  <= '0;
            end else begin
              high_m1_q <= high_m1;
              low_m1_q  <= low_m1;
              num_q     <= bus.pulse_num_i;
              phase_q   <= high_m1;
              cnt_q     <= CNT_W'(1);
              state_q   <= StActive;
              signal_q  <= ActLvl;
              lead_q    <= 1'b1;
              busy_q    <= 1'b1;
            end
          end
        end
        StActive: begin
          if (bus.abort_i) begin
            state_q  <= StIdle;
            signal_q <= IdleLvl;
            busy_q   <= 1'b0;
          end else if (phase_q == '0) begin
            state_q  <= StInactive;
            signal_q <= IdleLvl;
            phase_q  <= low_m1_q;
          end else begin
            phase_q <= phase_q - CNT_W'(1);
          end
        end
        StInactive: begin
          if (bus.abort_i) begin
            state_q  <= StIdle;
            signal_q <= IdleLvl;
            busy_q   <= 1'b0;
          end else if (phase_q == '0) begin
            if (cnt_q == num_q) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q  <= StActive;
              signal_q <= ActLvl;
              lead_q   <= 1'b1;
              cnt_q    <= cnt_q + CNT_W'(1);
              phase_q  <= high_m1_q;
            end
          end else begin
            phase_q <= phase_q - CNT_W'(1);
          end
        end
        default: begin
          state_q  <= StIdle;
          signal_q <= IdleLvl;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.signal_o    = signal_q;
  assign bus.lead_edge_o = lead_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.pulse_cnt_o = cnt_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen: two instances (idle-low 16-bit, idle-high 4-bit) checked
// cycle by cycle against a waveform computed from H, P, N and the start cycle.
module tb_pulse_train_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] hc = '0;
  logic [15:0] pc = '0;
  logic [15:0] nc = '0;
  int          sel = 0;

  int n_checks = 0;
  int n_fail   = 0;
  int train_id = 0;
  int last_cnt = 0;

  pulse_train_gen_if #(.CNT_W(16)) bus0 ();
  pulse_train_gen_if #(.CNT_W(4))  bus1 ();

  assign bus0.start_i         = start && (sel == 0);
  assign bus0.abort_i         = abort && (sel == 0);
  assign bus0.high_cycles_i   = hc;
  assign bus0.period_cycles_i = pc;
  assign bus0.pulse_num_i     = nc;
  assign bus1.start_i         = start && (sel == 1);
  assign bus1.abort_i         = abort && (sel == 1);
  assign bus1.high_cycles_i   = hc[3:0];
  assign bus1.period_cycles_i = pc[3:0];
  assign bus1.pulse_num_i     = nc[3:0];

  pulse_train_gen #(.EDGE_TYPE(1'b0), .CNT_W(16)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  pulse_train_gen #(.EDGE_TYPE(1'b1), .CNT_W(4))  dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  logic        o_sig, o_lead, o_busy, o_done;
  logic [15:0] o_cnt;

  always_comb begin
    if (sel == 0) begin
      o_sig  = bus0.signal_o;
      o_lead = bus0.lead_edge_o;
      o_busy = bus0.busy_o;
      o_done = bus0.done_o;
      o_cnt  = bus0.pulse_cnt_o;
    end else begin
      o_sig  = bus1.signal_o;
      o_lead = bus1.lead_edge_o;
      o_busy = bus1.busy_o;
      o_done = bus1.done_o;
      o_cnt  = {12'd0, bus1.pulse_cnt_o};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic es, input logic el, input logic eb,
                           input logic ed, input int ec);
    check({tag, ".signal"}, 32'(o_sig), 32'(es));
    check({tag, ".lead"},   32'(o_lead), 32'(el));
    check({tag, ".busy"},   32'(o_busy), 32'(eb));
    check({tag, ".done"},   32'(o_done), 32'(ed));
    check({tag, ".cnt"},    32'(o_cnt), ec);
  endtask

  function automatic logic idle_lvl();
    return (sel == 0) ? 1'b0 : 1'b1;
  endfunction

  // Start a train in the current cycle T and check cycles T+1 .. done (or abort+1).
  // a > 0 asserts abort during cycle T+a. Returns positioned in the final checked cycle.
  task automatic run_train(input int h, input int p, input int n, input int a, input bit spam);
    int   mask, hs, ps, nn, hm, pm, last, r, k, ph, ec;
    logic es, el, eb, ed, idl;
    mask = (sel == 0) ? 32'hFFFF : 32'hF;
    hm   = h & mask;
    pm   = p & mask;
    nn   = n & mask;
    hs   = (hm == 0) ? 1 : hm;
    ps   = (pm <= hs) ? hs + 1 : pm;
    idl  = idle_lvl();
    hc = 16'(h); pc = 16'(p); nc = 16'(n);
    start = 1'b1; abort = 1'b0;
    last = (nn == 0) ? 1 : nn * ps + 1;
    for (int rel = 1; rel <= last; rel++) begin
      step();
      if (nn == 0) begin
        es = idl; el = 1'b0; eb = 1'b0; ed = 1'b1; ec = 0;
      end else if (a > 0 && rel == a + 1) begin
        es = idl; el = 1'b0; eb = 1'b0; ed = 1'b0; ec = (a - 1) / ps + 1;
      end else if (rel - 1 < nn * ps) begin
        r  = rel - 1;
        k  = r / ps;
        ph = r % ps;
        es = (ph < hs) ? ~idl : idl;
        el = (ph == 0);
        eb = 1'b1; ed = 1'b0; ec = k + 1;
      end else begin
        es = idl; el = 1'b0; eb = 1'b0; ed = 1'b1; ec = nn;
      end
      check_all($sformatf("train%0d.c%0d", train_id, rel), es, el, eb, ed, ec);
      if (rel == last || (a > 0 && rel == a + 1)) begin
        start = 1'b0; abort = 1'b0; last_cnt = ec;
        break;
      end
      start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
      abort = (rel == a);
      hc = 16'($urandom); pc = 16'($urandom); nc = 16'($urandom);
    end
    train_id++;
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      step();
      check_all($sformatf("idle%0d.c%0d", train_id, i), idle_lvl(), 1'b0, 1'b0, 1'b0, last_cnt);
    end
  endtask

  initial begin
    int h, p, n, a, hs, ps;
    bit spam;

    // Reset state of both instances.
    step();
    step();
    sel = 0; #1;
    check_all("reset0", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    sel = 1; #1;
    check_all("reset1", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    sel = 0;
    rst = 1'b0;
    idle_cycles(2);

    run_train(2, 5, 3, 0, 1'b1);
    idle_cycles(3);

    sel = 1;
    run_train(0, 0, 2, 0, 1'b1);
    idle_cycles(2);

    sel = 0;
    run_train(5, 9, 0, 0, 1'b0);
    idle_cycles(2);

    // Abort in the second pulse's active phase.
    run_train(3, 6, 4, 8, 1'b1);
    idle_cycles(2);

    // Abort and start together while idle: nothing starts.
    hc = 16'd2; pc = 16'd4; nc = 16'd2;
    start = 1'b1; abort = 1'b1;
    step();
    check_all("abort_start.c1", 1'b0, 1'b0, 1'b0, 1'b0, last_cnt);
    start = 1'b0; abort = 1'b0;
    step();
    check_all("abort_start.c2", 1'b0, 1'b0, 1'b0, 1'b0, last_cnt);

    // Back-to-back: second start in the done cycle of the first.
    run_train(2, 4, 2, 0, 1'b0);
    run_train(1, 3, 2, 0, 1'b0);
    idle_cycles(1);

    // Maximum H and N on the narrow instance.
    sel = 1;
    run_train(15, 0, 15, 0, 1'b0);
    idle_cycles(1);
    run_train(7, 15, 1, 0, 1'b1);
    idle_cycles(1);

    // Reset mid-INACTIVE, with start held during reset.
    sel = 0;
    hc = 16'd3; pc = 16'd8; nc = 16'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    check_all("rst_pre", 1'b0, 1'b0, 1'b1, 1'b0, 1);
    rst = 1'b1; start = 1'b1;
    step();
    check_all("rst.c1", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    step();
    check_all("rst.c2", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    rst = 1'b0; start = 1'b0;
    last_cnt = 0;
    idle_cycles(3);

    // Randomised trains on both instances.
    for (int it = 0; it < 24; it++) begin
      sel  = int'($urandom_range(0, 1));
      h    = int'($urandom_range(0, 6));
      p    = int'($urandom_range(0, 12));
      n    = int'($urandom_range(0, 4));
      spam = 1'($urandom_range(0, 1));
      hs   = (h == 0) ? 1 : h;
      ps   = (p <= hs) ? hs + 1 : p;
      a    = 0;
      if (n > 0 && $urandom_range(0, 3) == 0) a = int'($urandom_range(1, n * ps));
      if ($urandom_range(0, 1) == 1) begin
        idle_cycles(int'($urandom_range(0, 2)));
      end else begin
        #1;
      end
      run_train(h, p, n, a, spam);
    end
    idle_cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
